seg_seq_scroller: RTL and testbench
===================================

// Module: seg_seq_scroller
// PURPOSE
//  Programmable digit-sequence player for multiplexed 7-segment displays. Holds up to
//  DEPTH digit codes in a write-loaded buffer. Scrolls the sequence across N_DIG
//  scanned digits at a divided step rate.
//  Sits between control logic (ID/score/count sources) and the board's common-anode
//  display pins.
// PARAMETERS
//  AW        3          buffer address width; DEPTH = 2**AW entries
//  N_DIG     4          number of physical display digits (1..DEPTH)
//  STEP_DIV  50000000   clk cycles per scroll step (>=2)
//  SCAN_DIV  50000      clk cycles per digit-scan slot (>=2)
// PORTS
//  clk      in   1       system clock, rising edge
//  rst_n    in   1       synchronous reset, active-low
//  clr      in   1       empty buffer, reset pointers
//  wr_en    in   1       write strobe; accepted only when !wr_full
//  wr_data  in   5       {dp_on, code[3:0]}
//  wr_full  out  1       len == DEPTH
//  run      in   1       1 = scrolling enabled, 0 = freeze current view
//  seg      out  7       {g,f,e,d,c,b,a}, active-low
//  dpt      out  1       decimal point, active-low
//  an       out  N_DIG   digit enables, one-hot active-low
//  pos      out  AW      current scroll base index
//  wrap     out  1       1-cycle pulse when base steps back to 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): seg=7'h7F, dpt=1, an=all 1, pos=0, wrap=0, len=0.
//   Also clears wr_ptr, dig, and both dividers.
//   Buffer RAM is not cleared; len=0 makes it invisible. Same state results mid-operation.
//  Write: wr_en && !wr_full -> mem[wr_ptr]<=wr_data, wr_ptr++, len++ (next cycle).
//   Write when full is dropped; no state changes.
//  clr: len=0, wr_ptr=0, base=0, step divider=0. Takes priority over wr_en and a step in the same cycle.
//  Step divider: counts only while run && len>0.
//   At STEP_DIV-1 it resets and base <= (base+1==len) ? 0 : base+1.
//   wrap=1 on that same update when the new base is 0. len==1 -> wrap pulses every step.
//   run=0 holds the divider count and base. Resuming continues the partial count.
//  Write coinciding with a step: the step uses the old len; the new len is visible next cycle.
//  Scan divider: free-running. At SCAN_DIV-1, dig <= (dig==N_DIG-1) ? 0 : dig+1.
//  Displayed slot: if dig >= len -> blank (seg=7'h7F, dpt=1).
//   Otherwise entry = mem[(base+dig) mod len]; seg=decode(code), dpt=~dp_on.
//   The modulo is a single conditional subtract, valid because base<len and dig<len.
//  seg, dpt, and an are registered. They change 1 clk after a dig/base/len update and
//   always change together, so there is no ghosting.
//  Decode (active-low):
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//  Codes 10..15 follow CONFIGURATION.
// CONFIGURATION
//  SEG_HEX_EN defined:
//   10..15 decode as A=08 b=03 C=46 d=21 E=06 F=0E, with dpt per dp_on.
//  SEG_HEX_EN undefined:
//   10..15 are errors: seg=7'h00 (all lit), dpt=0, regardless of dp_on.
// TESTING (STEP_DIV=4, SCAN_DIV=2, AW=3, N_DIG=4)
//  Load 0,0,0,3,2,1 with run=0, wait 8 clk.
//   -> an cycles E,D,B,7. seg shows 40,40,40,30. pos=0, wrap never.
//  Same load, run=1, 6 steps.
//   -> pos 1,2,3,4,5,0. wrap high exactly 1 clk at the 5->0 step.
//   -> at pos=4 the slots show 2,1,0,0.
//  Write 9 entries without clr.
//   -> wr_full=1 after the 8th. The 9th is ignored. len stays 8, mem[0] unchanged.
//  Load 2 entries.
//   -> slots dig=2,3 blank (7F, dpt=1).
//  clr and step in the same cycle.
//   -> len=0, pos=0, wrap=0, all slots blank next cycle.
//  rst_n=0 for 1 clk mid-scroll.
//   -> all outputs at reset values next cycle.
//  Code 4'hA written:
//   with SEG_HEX_EN -> seg=08.
//   without -> seg=00, dpt=0.

Source files
------------

// File: rtl/seg_seq_scroller.sv
// seg_seq_scroller: write-loaded digit buffer scrolled across a multiplexed,
// common-anode 7-segment display.
// Optional feature macro: SEG_HEX_EN (codes 10..15 show A,b,C,d,E,F instead of an
// all-lit error pattern).
module seg_seq_scroller #(
  parameter int unsigned AW       = 3,
  parameter int unsigned N_DIG    = 4,
  parameter int unsigned STEP_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [4:0]       wr_data,
  output logic             wr_full,
  input  logic             run,
  output logic [6:0]       seg,
  output logic             dpt,
  output logic [N_DIG-1:0] an,
  output logic [AW-1:0]    pos,
  output logic             wrap
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned SW    = $clog2(STEP_DIV);
  localparam int unsigned CW    = $clog2(SCAN_DIV);

  logic [4:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    base_q, base_d;
  logic [SW-1:0]    step_cnt_q, step_cnt_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [AW-1:0]    dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpt_q, dpt_d;
  logic [N_DIG-1:0] an_q, an_d;

  logic             wr_acc;
  logic             step_hit;
  logic [AW:0]      base_inc;
  logic [AW-1:0]    base_nxt;
  logic [AW:0]      idx_sum;
  logic [AW:0]      idx;
  logic [4:0]       rd_entry;
  logic [7:0]       dec;

  // Active-low segment decode; returns {dpt, seg}
  function automatic logic [7:0] decode(input logic [4:0] e);
    logic [6:0] s;
    logic       err;
    s   = 7'h7F;
    err = 1'b0;
    case (e[3:0])
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
`ifdef SEG_HEX_EN
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
`else
      default: err = 1'b1;
`endif
    endcase
    // An error lights everything, decimal point included
    return err ? 8'h00 : {~e[4], s};
  endfunction

  assign wr_full  = (len_q == {1'b1, {AW{1'b0}}});
  assign wr_acc   = wr_en && !wr_full && !clr;
  assign step_hit = run && (len_q != '0) && (step_cnt_q == SW'(STEP_DIV - 1));
  assign base_inc = {1'b0, base_q} + 1'b1;
  assign base_nxt = (base_inc == len_q) ? '0 : base_q + 1'b1;

  // Buffer write; contents survive reset and clr, len hides stale entries
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Next-state for buffer bookkeeping and the scroll step
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    base_d     = base_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      len_d      = '0;
      base_d     = '0;
      step_cnt_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        len_d    = len_q + 1'b1;
      end
      // The step sees the pre-write len
      if (run && (len_q != '0)) begin
        if (step_hit) begin
          step_cnt_d = '0;
          base_d     = base_nxt;
          wrap_d     = (base_nxt == '0);
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
    end
  end

  // Next-state for the free-running scan and the registered display drive
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_d      = dig_q;
    if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_d      = (dig_q == AW'(N_DIG - 1)) ? '0 : dig_q + 1'b1;
    end
    // base < len and dig < len, so one conditional subtract is a full modulo
    idx_sum  = {1'b0, base_q} + {1'b0, dig_q};
    idx      = (idx_sum >= len_q) ? idx_sum - len_q : idx_sum;
    rd_entry = mem[idx[AW-1:0]];
    dec      = decode(rd_entry);
    an_d     = ~(N_DIG'(1) << dig_q);
    if ({1'b0, dig_q} >= len_q) begin
      seg_d = 7'h7F;
      dpt_d = 1'b1;
    end else begin
      seg_d = dec[6:0];
      dpt_d = dec[7];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      len_q      <= '0;
      base_q     <= '0;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      dig_q      <= '0;
      seg_q      <= 7'h7F;
      dpt_q      <= 1'b1;
      an_q       <= '1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      base_q     <= base_d;
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      dpt_q      <= dpt_d;
      an_q       <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dpt  = dpt_q;
  assign an   = an_q;
  assign pos  = base_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_seq_scroller.sv
// Directed self-checking bench for seg_seq_scroller (small dividers for speed).
module tb_seg_seq_scroller;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, run;
  logic [4:0] wr_data;
  logic       wr_full, dpt, wrap;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] pos;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_seg [4];
  logic       exp_dpt [4];
  logic [2:0] exp_pos;

  seg_seq_scroller #(
    .AW(3), .N_DIG(4), .STEP_DIV(4), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .run(run), .seg(seg), .dpt(dpt), .an(an), .pos(pos),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] d);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int i = 0; i < 4; i++) exp_dpt[i] = d[i];
  endtask

  // Watch 8 clocks: every scanned slot must match, scan order must be 0,1,2,3
  task automatic check_slots(input string tag);
    int idx;
    int prev;
    logic [3:0] seen;
    prev = -1;
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      case (an)
        4'hE: idx = 0;
        4'hD: idx = 1;
        4'hB: idx = 2;
        4'h7: idx = 3;
        default: idx = -1;
      endcase
      check_eq({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg[idx]));
        check_eq({tag, "_dpt"}, 32'(dpt), 32'(exp_dpt[idx]));
        if (prev >= 0 && idx != prev) check_eq({tag, "_scan_order"}, idx, (prev + 1) % 4);
        seen[idx] = 1'b1;
        prev = idx;
      end
      check_eq({tag, "_pos"}, 32'(pos), 32'(exp_pos));
      check_eq({tag, "_wrap"}, 32'(wrap), 32'd0);
      tick();
    end
    check_eq({tag, "_all_slots"}, 32'(seen), 32'hF);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dpt"}, 32'(dpt), 32'd1);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_pos"}, 32'(pos), 32'd0);
    check_eq({tag, "_wrap"}, 32'(wrap), 32'd0);
    check_eq({tag, "_full"}, 32'(wr_full), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   wraps;
    int   got;
    logic [2:0] prev_pos;
    logic [2:0] want;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0; run = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;

    // Frozen view of 0,0,0,3,2,1
    wr(5'h00); wr(5'h00); wr(5'h00); wr(5'h03); wr(5'h02); wr(5'h01);
    tick();
    set_exp(7'h40, 7'h40, 7'h40, 7'h30, 4'hF);
    exp_pos = 3'd0;
    check_slots("frozen");

    // Scroll through six steps, freezing once at pos 4 to inspect the view
    run = 1'b1;
    prev_pos = 3'd0;
    wraps = 0;
    for (int k = 0; k < 6; k++) begin
      want = 3'((k + 1) % 6);
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        tick();
        if (wrap) wraps++;
        if (pos != prev_pos) got = 1;
      end
      check_eq("step_seen", got, 1);
      check_eq("step_pos", 32'(pos), 32'(want));
      check_eq("step_wrap", 32'(wrap), 32'(want == 3'd0));
      prev_pos = pos;
      if (pos == 3'd4) begin
        run = 1'b0;
        tick();
        set_exp(7'h24, 7'h79, 7'h40, 7'h40, 4'hF);
        exp_pos = 3'd4;
        check_slots("pos4");
        run = 1'b1;
      end
    end
    tick();
    if (wrap) wraps++;
    check_eq("wrap_pulse_len", 32'(wrap), 32'd0);
    check_eq("wrap_count", wraps, 1);
    run = 1'b0;

    // Fill to capacity; ninth write must be dropped
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) check_eq("full_before_8th", 32'(wr_full), 32'd0);
      wr(5'(i));
    end
    check_eq("full_after_8th", 32'(wr_full), 32'd1);
    wr(5'h08);
    check_eq("full_after_9th", 32'(wr_full), 32'd1);
    tick();
    set_exp(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
    exp_pos = 3'd0;
    check_slots("full");

    // Two entries: upper slots blank
    clr = 1'b1; tick(); clr = 1'b0;
    wr(5'h05); wr(5'h16);
    tick();
    set_exp(7'h12, 7'h02, 7'h7F, 7'h7F, 4'b1101);
    check_slots("short");

    // clr lands on the same edge as a step
    run = 1'b1;
    tick(); tick(); tick();
    check_eq("pre_clr_pos", 32'(pos), 32'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_step_pos", 32'(pos), 32'd0);
    check_eq("clr_step_wrap", 32'(wrap), 32'd0);
    check_eq("clr_step_full", 32'(wr_full), 32'd0);
    tick();
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    check_slots("clr_blank");
    run = 1'b0;

    // Reset mid-scroll
    wr(5'h01); wr(5'h02); wr(5'h03);
    run = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_eq("pre_reset_pos", 32'(pos), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset("midreset");
    run = 1'b0;

    // Codes above 9
    wr(5'h0A); wr(5'h1F);
    tick();
`ifdef SEG_HEX_EN
    set_exp(7'h08, 7'h0E, 7'h7F, 7'h7F, 4'b1101);
`else
    set_exp(7'h00, 7'h00, 7'h7F, 7'h7F, 4'b1100);
`endif
    exp_pos = 3'd0;
    check_slots("hex");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
